decoder_scan_ctrl: RTL and testbench



---
 rtl/decoder_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctrl
//   Sequencer feeding a 3-to-8 decoder. It walks channels 0..7, holding each
//   channel enabled for a programmable dwell time. An optional blanking gap
//   with the enable released separates consecutive channels, so at most one
//   decoder output is high in any cycle.
//
// Parameters
//   DWELL_W    width of the dwell input and of the dwell counter
//   BLANK_CYC  cycles with e=1 between channels (0 = no blanking)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   start       in   begin a scan (honoured only in IDLE)
//   stop        in   abort (honoured in any state, wins over start/advance)
//   cont        in   0 = single sweep, 1 = continuous; sampled with start
//   dwell       in   cycles per channel; sampled with start; 0 behaves as 1
//   x, y, z     out  decoder select, x = MSB
//   e           out  decoder enable, active-low
//   busy        out  high in ACTIVE or BLANK
//   sweep_done  out  one-cycle pulse at the end of a single sweep
//   dbg_state   out  current FSM state (IDLE=0, ACTIVE=1, BLANK=2)
//
// Handshake: start and stop are level-sampled every rising edge; there is no
// ready/acknowledge. A start seen in IDLE with stop low launches a scan that
// becomes visible (e=0) on the very next cycle.
// -----------------------------------------------------------------------------
module decoder_scan_ctrl #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  output logic               x,
  output logic               y,
  output logic               z,
  output logic               e,
  output logic               busy,
  output logic               sweep_done,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_BLANK  = 2'd2
  } state_t;

  // Blank counter only needs to hold BLANK_CYC-1; keep at least one bit so
  // the declaration stays legal when blanking is disabled.
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

  state_t               r_state;
  logic [2:0]           r_chan;
  logic [DWELL_W-1:0]   r_dcnt;
  logic [BW-1:0]        r_bcnt;
  logic [DWELL_W-1:0]   r_len;
  logic                 r_cont;
  logic                 r_e;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_nxt_state;
  logic [2:0]           w_nxt_chan;
  logic [DWELL_W-1:0]   w_nxt_dcnt;
  logic [BW-1:0]        w_nxt_bcnt;
  logic [DWELL_W-1:0]   w_nxt_len;
  logic                 w_nxt_cont;
  logic                 w_nxt_done;
  logic                 w_adv;
  logic [DWELL_W-1:0]   w_len;

  // A dwell of zero would make ACTIVE vanish; treat it as one cycle.
  assign w_len = (dwell == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_chan  = r_chan;
    w_nxt_dcnt  = r_dcnt;
    w_nxt_bcnt  = r_bcnt;
    w_nxt_len   = r_len;
    w_nxt_cont  = r_cont;
    w_nxt_done  = 1'b0;
    w_adv       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_nxt_state = S_ACTIVE;
          w_nxt_len   = w_len;
          w_nxt_cont  = cont;
          w_nxt_chan  = 3'd0;
          w_nxt_dcnt  = w_len - 1'b1;
        end
      end
      S_ACTIVE: begin
        if (stop) begin
          w_nxt_state = S_IDLE;
        end else if (r_dcnt == '0) begin
          if (BLANK_CYC > 0) begin
            w_nxt_state = S_BLANK;
            w_nxt_bcnt  = BLANK_LAST;
          end else begin
            w_adv = 1'b1;
          end
        end else begin
          w_nxt_dcnt = r_dcnt - 1'b1;
        end
      end
      S_BLANK: begin
        if (stop) begin
          w_nxt_state = S_IDLE;
        end else if (r_bcnt == '0) begin
          w_adv = 1'b1;
        end else begin
          w_nxt_bcnt = r_bcnt - 1'b1;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase

    // Advance to the next channel. Channel 7 either wraps (continuous) or
    // ends the sweep, leaving the select lines parked on 7.
    if (w_adv) begin
      if ((r_chan != 3'd7) || r_cont) begin
        w_nxt_chan  = r_chan + 3'd1;
        w_nxt_state = S_ACTIVE;
        w_nxt_dcnt  = r_len - 1'b1;
      end else begin
        w_nxt_state = S_IDLE;
        w_nxt_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_chan  <= 3'd0;
      r_dcnt  <= '0;
      r_bcnt  <= '0;
      r_len   <= '0;
      r_cont  <= 1'b0;
      r_e     <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_chan  <= w_nxt_chan;
      r_dcnt  <= w_nxt_dcnt;
      r_bcnt  <= w_nxt_bcnt;
      r_len   <= w_nxt_len;
      r_cont  <= w_nxt_cont;
      // Enable and busy come straight from flops so the decoder never sees
      // a decode glitch of the state bits.
      r_e     <= (w_nxt_state != S_ACTIVE);
      r_busy  <= (w_nxt_state != S_IDLE);
      r_done  <= w_nxt_done;
    end
  end

  assign x          = r_chan[2];
  assign y          = r_chan[1];
  assign z          = r_chan[0];
  assign e          = r_e;
  assign busy       = r_busy;
  assign sweep_done = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_ctrl
//   Two instances: dut (BLANK_CYC=2) and dut0 (BLANK_CYC=0). Expected output
//   vectors {e, busy, sweep_done, x, y, z} are queued when stimulus is driven
//   and popped one per cycle, sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, cont;
  logic [7:0] dwell;
  logic       start0, stop0, cont0;
  logic [7:0] dwell0;

  logic       x, y, z, e, busy, sweep_done;
  logic [1:0] dbg_state;
  logic       x0, y0, z0, e0, busy0, sweep_done0;
  logic [1:0] dbg_state0;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];
  logic [7:0] dec_q[$];
  logic [7:0] onehot [8];

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .dwell(dwell),
    .x(x), .y(y), .z(z), .e(e), .busy(busy), .sweep_done(sweep_done),
    .dbg_state(dbg_state)
  );

  decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .cont(cont0), .dwell(dwell0),
    .x(x0), .y(y0), .z(z0), .e(e0), .busy(busy0), .sweep_done(sweep_done0),
    .dbg_state(dbg_state0)
  );

  // Queue one full sweep: per channel, len cycles enabled then blank cycles
  // released, select lines on the channel throughout.
  task automatic push_sweep(input int len, input int blank);
    for (int ch = 0; ch < 8; ch++) begin
      for (int k = 0; k < len; k++) begin
        exp_q.push_back({1'b0, 1'b1, 1'b0, 3'(ch)});
        dec_q.push_back(onehot[ch]);
      end
      for (int k = 0; k < blank; k++) begin
        exp_q.push_back({1'b1, 1'b1, 1'b0, 3'(ch)});
        dec_q.push_back(8'h00);
      end
    end
  endtask

  task automatic test_reset;
    logic [5:0] obs, exp_v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {e, busy, sweep_done, x, y, z};
    checks++;
    if (obs !== 6'b100_000) begin
      failures++;
      $display("FAIL reset_hold: got %b expected %b", obs, 6'b100_000);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) exp_q.push_back(6'b100_000);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs   = {e, busy, sweep_done, x, y, z};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_idle: got %b expected %b", obs, exp_v);
      end
    end
  endtask

  task automatic test_single_sweep;
    logic [5:0] obs, exp_v;
    logic [7:0] dec_act, dec_exp;
    int first_e0, done_at, done_cnt, i;
    first_e0 = -1; done_at = -1; done_cnt = 0; i = 0;
    @(negedge clk);
    dwell = 8'd3; cont = 1'b0; start = 1'b1;
    push_sweep(3, 2);
    exp_q.push_back(6'b101_111);
    exp_q.push_back(6'b100_111);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp_v = exp_q.pop_front();
      obs   = {e, busy, sweep_done, x, y, z};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL sweep_cycle%0d: got %b expected %b", i, obs, exp_v);
      end
      if (dec_q.size() > 0) begin
        dec_exp = dec_q.pop_front();
        for (int k = 0; k < 8; k++) dec_act[k] = !e && ({x, y, z} == 3'(k));
        checks++;
        if (dec_act !== dec_exp) begin
          failures++;
          $display("FAIL sweep_onehot%0d: got %h expected %h", i, dec_act, dec_exp);
        end
      end
      if (!e && first_e0 < 0) first_e0 = i;
      if (sweep_done) begin
        done_cnt++;
        done_at = i;
      end
      i++;
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL sweep_done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (done_at - first_e0 !== 40) begin
      failures++;
      $display("FAIL sweep_duration: got %0d expected 40", done_at - first_e0);
    end
  endtask

  task automatic test_fast_continuous;
    logic [5:0] obs, exp_v;
    @(negedge clk);
    dwell0 = 8'd0; cont0 = 1'b1; start0 = 1'b1;
    for (int i = 0; i < 24; i++) exp_q.push_back({1'b0, 1'b1, 1'b0, 3'(i % 8)});
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start0 = 1'b0;
      exp_v = exp_q.pop_front();
      obs   = {e0, busy0, sweep_done0, x0, y0, z0};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL fast_cont: got %b expected %b", obs, exp_v);
      end
    end
    // Stop after channel 7 was shown: idle next cycle, selects parked on 7.
    stop0 = 1'b1;
    repeat (4) exp_q.push_back(6'b100_111);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      stop0 = 1'b0;
      exp_v = exp_q.pop_front();
      obs   = {e0, busy0, sweep_done0, x0, y0, z0};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL fast_stop: got %b expected %b", obs, exp_v);
      end
    end
  endtask

  task automatic test_start_stop_same;
    logic [5:0] obs, exp_v;
    @(negedge clk);
    dwell = 8'd3; cont = 1'b0; start = 1'b1; stop = 1'b1;
    repeat (5) exp_q.push_back(6'b100_111);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      exp_v = exp_q.pop_front();
      obs   = {e, busy, sweep_done, x, y, z};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL start_stop_same: got %b expected %b", obs, exp_v);
      end
    end
  endtask

  task automatic test_start_ignored;
    logic [5:0] obs, exp_v;
    int i;
    i = 0;
    @(negedge clk);
    dwell = 8'd3; cont = 1'b0; start = 1'b1;
    push_sweep(3, 2);
    dec_q.delete();
    exp_q.push_back(6'b101_111);
    exp_q.push_back(6'b100_111);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp_v = exp_q.pop_front();
      obs   = {e, busy, sweep_done, x, y, z};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL start_ignored%0d: got %b expected %b", i, obs, exp_v);
      end
      if (i == 5) begin
        start = 1'b1; dwell = 8'd9; cont = 1'b1;
      end
      i++;
    end
    dwell = 8'd3; cont = 1'b0;
  endtask

  task automatic test_abort_last;
    logic [5:0] obs, exp_v;
    int i, done_cnt;
    i = 0; done_cnt = 0;
    @(negedge clk);
    dwell = 8'd3; cont = 1'b0; start = 1'b1;
    push_sweep(3, 2);
    dec_q.delete();
    repeat (4) exp_q.push_back(6'b100_111);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      exp_v = exp_q.pop_front();
      obs   = {e, busy, sweep_done, x, y, z};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL abort_last%0d: got %b expected %b", i, obs, exp_v);
      end
      if (sweep_done) done_cnt++;
      // Cycle 39 is channel 7's final blank cycle: stop during it.
      if (i == 39) stop = 1'b1;
      i++;
    end
    checks++;
    if (done_cnt !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d expected 0", done_cnt);
    end
  endtask

  task automatic test_async_reset;
    logic [5:0] obs, exp_v;
    @(negedge clk);
    dwell = 8'd3; cont = 1'b0; start = 1'b1;
    push_sweep(3, 2);
    dec_q.delete();
    // Keep only up to the first cycle of channel 5 (index 25).
    while (exp_q.size() > 26) void'(exp_q.pop_back());
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp_v = exp_q.pop_front();
      obs   = {e, busy, sweep_done, x, y, z};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL async_pre: got %b expected %b", obs, exp_v);
      end
    end
    #2 rst = 1'b1;
    #1;
    obs = {e, busy, sweep_done, x, y, z};
    checks++;
    if (obs !== 6'b100_000) begin
      failures++;
      $display("FAIL async_reset_now: got %b expected %b", obs, 6'b100_000);
    end
    #2 rst = 1'b0;
    repeat (10) exp_q.push_back(6'b100_000);
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs   = {e, busy, sweep_done, x, y, z};
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL async_post: got %b expected %b", obs, exp_v);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) onehot[k] = 8'h01 << k;
    rst = 1'b1;
    start = 1'b0; stop = 1'b0; cont = 1'b0; dwell = 8'd0;
    start0 = 1'b0; stop0 = 1'b0; cont0 = 1'b0; dwell0 = 8'd0;
    test_reset();
    test_single_sweep();
    test_fast_continuous();
    test_start_stop_same();
    test_start_ignored();
    test_abort_last();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
